// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. It processes WIDTH-bit operands LSB-first, one bit per
// clock, through a single full-adder/full-subtractor slice.
// Optional build macro: SERIAL_ADDSUB_OVF_EN adds an 'ovf' output that flags
// signed two's-complement overflow.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; result/cout hold the last operation
// S_RUN  | one result bit per clock, LSB first; busy=1
// S_DONE | result/cout final; done=1 for this cycle only; start accepted
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic           mode_r;
    logic           cb;
    logic [CW-1:0]  cnt;

    logic           ai;
    logic           bi;
    logic           s;
    logic           cb_nxt;
    logic           accept;
    logic           last_bit;

    // One full-adder / full-subtractor slice working on the current operand LSBs.
    always_comb begin
        ai       = sh_a[0];
        bi       = sh_b[0];
        s        = ai ^ bi ^ cb;
        cb_nxt   = mode_r ? ((~ai & bi) | (~(ai ^ bi) & cb))
                          : ((ai & bi) | (ai & cb) | (bi & cb));
        accept   = start && (state != S_RUN);
        last_bit = (state == S_RUN) && (cnt == LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, then shift the operands and the result one bit per clock.
    // Stale result bits from the previous operation shift out as the new bits shift in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a   <= '0;
            sh_b   <= '0;
            mode_r <= 1'b0;
            cb     <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            sh_a   <= a;
            sh_b   <= b;
            mode_r <= mode;
            cb     <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (state == S_RUN) begin
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            result <= {s, result[WIDTH-1:1]};
            cb     <= cb_nxt;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                cout <= cb_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
                // At the last bit, ai and bi are the operand signs and s is the result sign.
                ovf  <= mode_r ? ((ai != bi) && (s != ai))
                               : ((ai == bi) && (s != ai));
`endif
            end
        end
    end

endmodule
